data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder side of the core's memory-stage load/store request interface.
//  - Accepts one request at a time over a valid/ready handshake.
//  - Inserts a configurable number of wait states.
//  - Performs a byte-strobed write, or a word read, on internal word storage.
//  - Returns a single-cycle response.
//  - Drives busy so the hazard unit can stall the pipeline while a request is outstanding.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; storage depth is 2**ADDR_WIDTH 32-bit words
//  WAIT_CYCLES  2   wait states between request accept and access (0..15)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_write  in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  req_wstrb  in   4   byte enables; bit i enables byte lane i
//  req_ready  out  1   responder can accept a request this cycle
//  rsp_valid  out  1   response strobe, one cycle wide
//  rsp_rdata  out  32  load data; 0 for stores and for errors
//  rsp_err    out  1   misaligned or out-of-range access
//  busy       out  1   request outstanding; feeds the pipeline stall
// BEHAVIOUR
//  - Reset (rst=0, asynchronous):
//    - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
//    - Storage contents are NOT cleared.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE:
//    - req_ready=1.
//    - On req_valid: latch write, addr, wdata and wstrb; load counter=WAIT_CYCLES.
//    - Go to WAIT, or directly to RESP when WAIT_CYCLES=0.
//  - WAIT:
//    - req_ready=0.
//    - Counter decrements each cycle; on the cycle it reaches 1, go to RESP.
//  - Storage is accessed on the edge that enters RESP:
//    - Store: commits the enabled bytes of the latched wdata.
//    - Load: registers the addressed word into rsp_rdata.
//  - RESP:
//    - rsp_valid=1 for exactly one cycle, req_ready=0.
//    - Go to IDLE on the next edge; rsp_rdata and rsp_err return to 0.
//  - Latency: accept at edge N gives rsp_valid high in cycle N+WAIT_CYCLES+1.
//  - Throughput: earliest next accept is in the cycle after rsp_valid, i.e. one request per WAIT_CYCLES+2 cycles.
//  - busy = (state != IDLE). It is combinational from state only, with no path from req_*.
//  - Error conditions, evaluated on the latched request:
//    - addr[1:0] != 0, or addr[31:ADDR_WIDTH+2] != 0 -> rsp_err=1.
//    - On error: no storage write, rsp_rdata=0, rsp_valid is still issued.
//  - Partial strobes: a store with wstrb=0 is a legal no-op store and still acks.
//  - Latched fields are stable: req_* changes after accept have no effect on the outstanding request.
//  - req_valid deasserted in IDLE: no state change.
//  - Reset mid-operation:
//    - Reset in WAIT aborts the request with no write and no response.
//    - Reset in RESP suppresses rsp_valid; the write has already committed.
//  - Address rollover: only word index addr[ADDR_WIDTH+1:2] selects storage. There is no wrap, because high bits go to the error path.
// STRUCTURE
//  - Shared package riscv_mem_pkg:
//    - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
//    - BYTE_LANES=4 and the WORD_BYTES_LOG2=2 constant.
//  - Sub-module dmem_array:
//    - Synchronous single-port word RAM with a 4-bit byte write-enable, a registered read port and no reset.
//    - The FSM, counter and error logic stay in data_mem_responder.
// TESTING
//  1. Reset, then a store then a load at addr 0x10.
//     - Stimulus: WAIT_CYCLES=2; store wdata 0xDEADBEEF with wstrb 4'hF; then load addr 0x10.
//     - Store: rsp_valid 3 cycles after accept, rsp_err=0.
//     - Load: rsp_rdata=0xDEADBEEF.
//  2. Byte-lane merge at addr 0x20.
//     - Stimulus: store 0x11223344 with wstrb=F; then store 0xAABBCCDD with wstrb=4'b0101; then load.
//     - Required: rsp_rdata=0x11BB33DD.
//  3. Error paths, checked by a following load of addr 0x00.
//     - Load addr 0x22 -> rsp_err=1, rsp_rdata=0.
//     - Store to addr 0x1000 with ADDR_WIDTH=10 -> rsp_err=1, word 0 unchanged.
//  4. Handshake and stall.
//     - Stimulus: req_valid held high continuously.
//     - Required: req_ready and busy are complementary every cycle, and accepts occur every 4 cycles.
//     - Required: changing req_wdata during WAIT does not alter the stored value.
//  5. Reset mid-WAIT.
//     - Stimulus: assert rst low while a store to 0x30 is in WAIT.
//     - Required: no rsp_valid; a later load of 0x30 returns the prior contents.
//     - Required: all outputs return to their reset values asynchronously.
//  6. WAIT_CYCLES=0 build.
//     - Required: rsp_valid in the cycle after accept; a back-to-back store then load sees the new data.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-stage load/store responder.
// Contains the FSM state encoding and the word/byte-lane constants.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam int BYTE_LANES      = 4;
  localparam int WORD_BYTES_LOG2 = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the core's memory stage and the responder.
// The core uses the master modport and the responder uses the slave modport.
interface data_mem_responder_if;
  import riscv_mem_pkg::*;

  logic                  req_valid;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [BYTE_LANES-1:0] req_wstrb;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Read returns the old word on a write cycle; the responder only uses it for loads.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: accepts one load/store, inserts wait states, accesses the
// word RAM on the edge entering RESP and returns a single-cycle response.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lat_write_q, lat_write_d;
  logic [31:0]           lat_addr_q, lat_addr_d;
  logic [31:0]           lat_wdata_q, lat_wdata_d;
  logic [BYTE_LANES-1:0] lat_wstrb_q, lat_wstrb_d;

  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [BYTE_LANES-1:0] acc_wstrb;
  logic                  acc_err;
  logic                  enter_resp;
  logic                  ram_en;
  logic [BYTE_LANES-1:0] ram_we;
  logic [31:0]           ram_rdata;
  logic                  lat_err;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[WORD_BYTES_LOG2-1:0] != '0) || (a[31:ADDR_WIDTH+WORD_BYTES_LOG2] != '0);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_wstrb_q <= lat_wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_wstrb_d = lat_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          lat_write_d = bus.req_write;
          lat_addr_d  = bus.req_addr;
          lat_wdata_d = bus.req_wdata;
          lat_wstrb_d = bus.req_wstrb;
          cnt_d       = WAIT_INIT;
          state_d     = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    acc_write  = (state_q == ST_IDLE) ? bus.req_write : lat_write_q;
    acc_addr   = (state_q == ST_IDLE) ? bus.req_addr  : lat_addr_q;
    acc_wdata  = (state_q == ST_IDLE) ? bus.req_wdata : lat_wdata_q;
    acc_wstrb  = (state_q == ST_IDLE) ? bus.req_wstrb : lat_wstrb_q;
    acc_err    = addr_err(acc_addr);
    enter_resp = ((state_q == ST_IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
                 ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    ram_en     = enter_resp && !acc_err;
    ram_we     = (ram_en && acc_write) ? acc_wstrb : '0;
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_addr[ADDR_WIDTH+WORD_BYTES_LOG2-1:WORD_BYTES_LOG2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    lat_err       = addr_err(lat_addr_q);
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_err   = (state_q == ST_RESP) && lat_err;
    bus.rsp_rdata = ((state_q == ST_RESP) && !lat_write_q && !lat_err) ? ram_rdata : 32'd0;
    busy          = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a WAIT_CYCLES=2 instance driven from a vector
// table plus handshake/reset sequences, and a WAIT_CYCLES=0 instance for back-to-back access.
module tb_data_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk;
  logic rst;
  logic busy0, busy1;
  int   cyc;
  int   checks;
  int   errors;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0)
  );
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input bit v, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (sel == 0) begin
      bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = a;
      bus0.req_wdata = d; bus0.req_wstrb = s;
    end else begin
      bus1.req_valid = v; bus1.req_write = wr; bus1.req_addr = a;
      bus1.req_wdata = d; bus1.req_wstrb = s;
    end
  endtask

  function automatic bit rdy(input int sel);
    return (sel == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  // Drives one request until accepted; afterwards scrambles the request fields so that a
  // responder relying on live inputs instead of latched ones gets caught.
  task automatic do_req(input int sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_err,
                        input bit expect_rsp);
    bit   acc;
    int   budget;
    exp_t e;
    acc    = 1'b0;
    budget = 0;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, d, s);
    while (!acc && budget < 50) begin
      if (rdy(sel)) acc = 1'b1;
      else begin
        @(negedge clk);
        budget++;
      end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut=%0d addr=0x%08h not accepted within 50 cycles", sel, a);
    end else if (expect_rsp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + 1 + ((sel == 0) ? W0 : W1);
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    drive(sel, 1'b0, ~wr, a ^ 32'h4, ~d, ~s);
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (((sel == 0) ? q0.size() : q1.size()) != 0) begin
      errors++;
      $display("FAIL rsp_timeout dut=%0d pending=%0d required=0", sel,
               (sel == 0) ? q0.size() : q1.size());
      if (sel == 0) q0.delete(); else q1.delete();
    end
  endtask

  // Response monitors: every rsp_valid must match the oldest expectation, and response
  // data must read as zero whenever no response is being presented.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.rsp_valid === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp0 actual=rsp_valid required=no response (cyc %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("rsp0_rdata", bus0.rsp_rdata, e.rdata);
        chk("rsp0_err", {31'd0, bus0.rsp_err}, {31'd0, e.err});
        chk("rsp0_latency_cyc", cyc, e.cyc);
      end
    end else begin
      chk("idle0_rdata_err", {bus0.rsp_rdata[30:0], bus0.rsp_err}, 32'd0);
    end
    if (bus1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp1 actual=rsp_valid required=no response (cyc %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("rsp1_rdata", bus1.rsp_rdata, e.rdata);
        chk("rsp1_err", {31'd0, bus1.rsp_err}, {31'd0, e.err});
        chk("rsp1_latency_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"}, {31'd0, bus0.req_ready}, 32'd1);
    chk({tag, "_busy0"},  {31'd0, busy0}, 32'd0);
    chk({tag, "_valid0"}, {31'd0, bus0.rsp_valid}, 32'd0);
    chk({tag, "_err0"},   {31'd0, bus0.rsp_err}, 32'd0);
    chk({tag, "_rdata0"}, bus0.rsp_rdata, 32'd0);
    chk({tag, "_ready1"}, {31'd0, bus1.req_ready}, 32'd1);
    chk({tag, "_busy1"},  {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    int accepts;
    int last_acc;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0022, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0F0F_0F0F, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0030, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0};

    #3 rst = 1'b0;
    #1 chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_req(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
             vecs[i].exp_rd, vecs[i].exp_err, 1'b1);
      wait_idle(0);
    end

    // req_valid held high: one accept every W0+2 cycles, ready and busy complementary.
    accepts  = 0;
    last_acc = -1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      chk("ready_vs_busy", {31'd0, bus0.req_ready}, {31'd0, ~busy0});
      if (bus0.req_ready) begin
        if (last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, W0 + 2);
        last_acc = cyc + 1;
        accepts++;
        q0.push_back('{32'hDEAD_BEEF, 1'b0, cyc + 1 + W0});
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("stream_accepts", accepts, 4);
    wait_idle(0);

    // Latched write data must survive input changes during WAIT (do_req scrambles them).
    do_req(0, 1'b1, 32'h44, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_idle(0);
    do_req(0, 1'b0, 32'h44, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    wait_idle(0);

    // Reset while a store to 0x30 sits in WAIT: aborted, no response, no write.
    do_req(0, 1'b1, 32'h30, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b0, 1'b0);
    chk("busy_in_wait", {31'd0, busy0}, 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midwait");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, 1'b1);
    wait_idle(0);

    // Zero wait states: back-to-back store then load sees the new data.
    do_req(1, 1'b1, 32'h50, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0, 1'b1);
    do_req(1, 1'b0, 32'h50, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 1'b1);
    do_req(1, 1'b1, 32'h50, 32'hFFFF_FFFF, 4'h2, 32'h0, 1'b0, 1'b1);
    do_req(1, 1'b0, 32'h50, 32'h0, 4'h0, 32'h1357_FFDF, 1'b0, 1'b1);
    do_req(1, 1'b0, 32'h52, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    wait_idle(1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
